// File: rtl/shift_add_multiplier_4_bit_pkg.sv
// Shared definitions for the 4x4 shift-and-add multiplier: state encoding,
// operand width, step count and the right-shift helper used by the datapath.
package shift_add_multiplier_4_bit_pkg;

    // Operand width; the downstream carry-lookahead adder is fixed at 4 bits.
    localparam int WIDTH = 4;

    // One partial-product step per multiplier bit.
    localparam int STEPS = 4;

    // Value of the step counter on the final partial-product step.
    localparam logic [1:0] LAST_STEP = 2'(STEPS - 1);

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Right shift of the concatenation {carry, accumulator, multiplier} after
    // the optional add. The incoming 5-bit partial is {C', A'}; the returned
    // byte is {new A, new Q}. The carry always shifts into A[3] and C clears.
    function automatic logic [7:0] shift_step(input logic [4:0] partial,
                                              input logic [3:0] q_cur);
        return {partial, q_cur[3:1]};
    endfunction

endpackage

// File: rtl/shift_add_multiplier_4_bit_if.sv
// Start/busy/done handshake bundle between a requester and the multiplier.
interface shift_add_multiplier_4_bit_if;

    logic       i_start;
    logic [3:0] i_multiplicand;
    logic [3:0] i_multiplier;
    logic       o_busy;
    logic       o_done;
    logic [7:0] o_product;

    // Requester side: issues operands and start, observes the result.
    modport master (
        output i_start,
        output i_multiplicand,
        output i_multiplier,
        input  o_busy,
        input  o_done,
        input  o_product
    );

    // Multiplier side: consumes the request, reports status and product.
    modport slave (
        input  i_start,
        input  i_multiplicand,
        input  i_multiplier,
        output o_busy,
        output o_done,
        output o_product
    );

endinterface

// File: rtl/shift_add_multiplier_4_bit_cla.sv
// 4-bit carry-lookahead adder with no carry-in; the result is {cout, sum}.
module carry_lookahead_adder_4_bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [4:0] result
);

    logic [3:0] gen;
    logic [3:0] prop;
    logic [4:0] carry;

    // Generate/propagate terms and fully expanded lookahead carries.
    always_comb begin
        gen      = a & b;
        prop     = a ^ b;
        carry    = 5'd0;
        carry[0] = 1'b0;
        carry[1] = gen[0];
        carry[2] = gen[1] | (prop[1] & gen[0]);
        carry[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0]);
        carry[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
                 | (prop[3] & prop[2] & prop[1] & gen[0]);
        result   = {carry[4], prop ^ carry[3:0]};
    end

endmodule

// File: rtl/shift_add_multiplier_4_bit.sv
// Sequential 4x4 unsigned shift-and-add multiplier. One partial-product step
// per clock through the carry-lookahead adder; the product is reported with a
// one-cycle done pulse and held until the next accepted start.
module shift_add_multiplier_4_bit
    import shift_add_multiplier_4_bit_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    shift_add_multiplier_4_bit_if.slave  bus
);

    // The adder is hard-wired to 4 bits, so no other width can be built.
    if (WIDTH != shift_add_multiplier_4_bit_pkg::WIDTH) begin : g_width_check
        $error("shift_add_multiplier_4_bit: WIDTH must be 4");
    end

    state_t           state;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] q_reg;
    logic             c_reg;
    logic [1:0]       count;
    logic             busy_reg;
    logic             done_reg;
    logic [7:0]       product_reg;

    logic [4:0]       add_result;
    logic [4:0]       partial;
    logic [7:0]       step_next;

    carry_lookahead_adder_4_bit u_adder (
        .a      (a_reg),
        .b      (m_reg),
        .result (add_result)
    );

    // Conditional add on Q[0] followed by the right shift. C is cleared by
    // every shift, so the no-add path is effectively {0, A}.
    always_comb begin
        partial   = q_reg[0] ? add_result : {c_reg, a_reg};
        step_next = shift_step(partial, q_reg);
    end

    // Controller and datapath registers; reset aborts any operation at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            m_reg       <= '0;
            a_reg       <= '0;
            q_reg       <= '0;
            c_reg       <= 1'b0;
            count       <= 2'd0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            product_reg <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        m_reg    <= bus.i_multiplicand;
                        q_reg    <= bus.i_multiplier;
                        a_reg    <= '0;
                        c_reg    <= 1'b0;
                        count    <= 2'd0;
                        busy_reg <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    a_reg <= step_next[7:4];
                    q_reg <= step_next[3:0];
                    c_reg <= 1'b0;
                    count <= count + 2'd1;
                    if (count == LAST_STEP) begin
                        product_reg <= step_next;
                        done_reg    <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    done_reg <= 1'b0;
                    busy_reg <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    done_reg <= 1'b0;
                    busy_reg <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_busy    = busy_reg;
    assign bus.o_done    = done_reg;
    assign bus.o_product = product_reg;

endmodule

// File: tb/tb_shift_add_multiplier_4_bit.sv
// Self-checking bench for the 4x4 shift-and-add multiplier. Expected products
// come from plain integer multiplication; expected timing from the handshake
// rules (done four cycles after accept, busy for five, restart every six).
module tb_shift_add_multiplier_4_bit;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    shift_add_multiplier_4_bit_if bus ();

    shift_add_multiplier_4_bit #(.WIDTH(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case anything stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Launch one operation and observe eight cycles after the accepting edge.
    // Only captures observations; each test compares them itself.
    task automatic do_op(input logic [3:0] m, input logic [3:0] q,
                         output int done_at, output int pulses,
                         output int busy_cnt, output logic [7:0] prod,
                         output logic stable);
        logic [7:0] prev;
        @(negedge clk);
        bus.i_start        = 1'b1;
        bus.i_multiplicand = m;
        bus.i_multiplier   = q;
        @(posedge clk);
        #1;
        bus.i_start        = 1'b0;
        bus.i_multiplicand = 4'($urandom);
        bus.i_multiplier   = 4'($urandom);
        prev     = bus.o_product;
        done_at  = -1;
        pulses   = 0;
        busy_cnt = 0;
        stable   = 1'b1;
        prod     = 8'h00;
        for (int t = 0; t < 8; t++) begin
            if (t > 0) begin
                @(posedge clk);
                #1;
            end
            if (bus.o_busy === 1'b1) busy_cnt++;
            if (bus.o_done === 1'b1) begin
                pulses++;
                if (done_at < 0) begin
                    done_at = t;
                    prod    = bus.o_product;
                end
            end else if (done_at < 0) begin
                if (bus.o_product !== prev) stable = 1'b0;
            end else if (bus.o_product !== prod) begin
                stable = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n              = 1'b1;
        bus.i_start        = 1'b0;
        bus.i_multiplicand = 4'd0;
        bus.i_multiplier   = 4'd0;
        #1 rst_n = 1'b0;
        #2;
        total++;
        if ({bus.o_busy, bus.o_done, bus.o_product} !== 10'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got busy=%b done=%b product=%h, want 0 0 00",
                     bus.o_busy, bus.o_done, bus.o_product);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int done_at, pulses, busy_cnt;
        logic [7:0] prod;
        logic stable;
        do_op(4'd6, 4'd3, done_at, pulses, busy_cnt, prod, stable);
        total++;
        if (prod !== 8'h12) begin
            bad++;
            $display("[TB] FAIL basic_product: got %h, want 12", prod);
        end
        total++;
        if (done_at !== 4 || pulses !== 1) begin
            bad++;
            $display("[TB] FAIL basic_done_timing: got cycle=%0d pulses=%0d, want cycle=4 pulses=1",
                     done_at, pulses);
        end
        total++;
        if (busy_cnt !== 5) begin
            bad++;
            $display("[TB] FAIL basic_busy_length: got %0d cycles, want 5", busy_cnt);
        end
        total++;
        if (stable !== 1'b1) begin
            bad++;
            $display("[TB] FAIL basic_product_stable: product changed outside final step, got %b want 1",
                     stable);
        end
    endtask

    task automatic test_carry();
        int done_at, pulses, busy_cnt;
        logic [7:0] prod;
        logic stable;
        do_op(4'd15, 4'd15, done_at, pulses, busy_cnt, prod, stable);
        total++;
        if (prod !== 8'hE1) begin
            bad++;
            $display("[TB] FAIL carry_15x15: got %h, want e1", prod);
        end
    endtask

    task automatic test_zero();
        int done_at, pulses, busy_cnt;
        logic [7:0] prod;
        logic stable;
        do_op(4'd0, 4'd9, done_at, pulses, busy_cnt, prod, stable);
        total++;
        if (prod !== 8'h00 || done_at !== 4 || busy_cnt !== 5) begin
            bad++;
            $display("[TB] FAIL zero_0x9: got product=%h cycle=%0d busy=%0d, want 00 4 5",
                     prod, done_at, busy_cnt);
        end
        do_op(4'd9, 4'd0, done_at, pulses, busy_cnt, prod, stable);
        total++;
        if (prod !== 8'h00 || done_at !== 4 || busy_cnt !== 5) begin
            bad++;
            $display("[TB] FAIL zero_9x0: got product=%h cycle=%0d busy=%0d, want 00 4 5",
                     prod, done_at, busy_cnt);
        end
    endtask

    task automatic test_ignore_start();
        int pulses;
        int done_at;
        int late_busy;
        logic [7:0] prod;
        @(negedge clk);
        bus.i_start        = 1'b1;
        bus.i_multiplicand = 4'd5;
        bus.i_multiplier   = 4'd7;
        @(posedge clk);
        #1;
        pulses    = 0;
        done_at   = -1;
        late_busy = 0;
        prod      = 8'h00;
        for (int t = 0; t < 9; t++) begin
            if (t > 0) begin
                @(posedge clk);
                #1;
            end
            if (bus.o_done === 1'b1) begin
                pulses++;
                if (done_at < 0) begin
                    done_at = t;
                    prod    = bus.o_product;
                end
            end
            if (t >= 5 && bus.o_busy !== 1'b0) late_busy++;
            if (t < 4) begin
                bus.i_start        = ~bus.i_start;
                bus.i_multiplicand = 4'($urandom);
                bus.i_multiplier   = 4'($urandom);
            end else begin
                bus.i_start = 1'b0;
            end
        end
        total++;
        if (prod !== 8'h23 || done_at !== 4) begin
            bad++;
            $display("[TB] FAIL ignore_start_result: got product=%h cycle=%0d, want 23 4",
                     prod, done_at);
        end
        total++;
        if (pulses !== 1 || late_busy !== 0) begin
            bad++;
            $display("[TB] FAIL ignore_start_restart: got pulses=%0d late_busy=%0d, want 1 0",
                     pulses, late_busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops_m [3] = '{4'd1, 4'd2, 4'd13};
        logic [3:0] ops_q [3] = '{4'd15, 4'd8, 4'd11};
        logic [7:0] expected [$];
        int seen;
        for (int i = 0; i < 3; i++) expected.push_back(8'(ops_m[i] * ops_q[i]));
        seen = 0;
        @(negedge clk);
        bus.i_start        = 1'b1;
        bus.i_multiplicand = ops_m[0];
        bus.i_multiplier   = ops_q[0];
        @(posedge clk);
        #1;
        for (int t = 0; t < 19; t++) begin
            if (t > 0) begin
                @(posedge clk);
                #1;
            end
            if (bus.o_done === 1'b1) begin
                total++;
                if (expected.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL b2b_extra_done: got done at cycle %0d, want none", t);
                end else if (bus.o_product !== expected[0] || t !== 4 + 6 * seen) begin
                    bad++;
                    $display("[TB] FAIL b2b_op%0d: got product=%h cycle=%0d, want %h cycle=%0d",
                             seen, bus.o_product, t, expected[0], 4 + 6 * seen);
                end
                if (expected.size() != 0) void'(expected.pop_front());
                seen++;
            end
            if (t == 0) begin
                bus.i_multiplicand = ops_m[1];
                bus.i_multiplier   = ops_q[1];
            end else if (t == 6) begin
                bus.i_multiplicand = ops_m[2];
                bus.i_multiplier   = ops_q[2];
            end else if (t == 12) begin
                bus.i_start = 1'b0;
            end
        end
        total++;
        if (seen !== 3 || bus.o_busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_count: got %0d results busy=%b, want 3 results busy=0",
                     seen, bus.o_busy);
        end
    endtask

    task automatic test_async_reset();
        int done_seen;
        int done_at, pulses, busy_cnt;
        logic [7:0] prod;
        logic stable;
        @(negedge clk);
        bus.i_start        = 1'b1;
        bus.i_multiplicand = 4'd9;
        bus.i_multiplier   = 4'd9;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.o_busy, bus.o_done, bus.o_product} !== 10'd0) begin
            bad++;
            $display("[TB] FAIL async_reset_outputs: got busy=%b done=%b product=%h, want 0 0 00",
                     bus.o_busy, bus.o_done, bus.o_product);
        end
        done_seen = 0;
        for (int t = 0; t < 6; t++) begin
            @(posedge clk);
            #1;
            if (bus.o_done !== 1'b0) done_seen++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(posedge clk);
            #1;
            if (bus.o_done !== 1'b0) done_seen++;
        end
        total++;
        if (done_seen !== 0) begin
            bad++;
            $display("[TB] FAIL async_reset_no_done: got %0d done cycles, want 0", done_seen);
        end
        do_op(4'd4, 4'd4, done_at, pulses, busy_cnt, prod, stable);
        total++;
        if (prod !== 8'h10 || done_at !== 4) begin
            bad++;
            $display("[TB] FAIL after_reset_4x4: got product=%h cycle=%0d, want 10 4",
                     prod, done_at);
        end
    endtask

    task automatic test_random();
        int done_at, pulses, busy_cnt;
        logic [7:0] prod;
        logic stable;
        logic [3:0] m;
        logic [3:0] q;
        int want;
        for (int i = 0; i < 24; i++) begin
            m    = 4'($urandom);
            q    = 4'($urandom);
            want = int'(m) * int'(q);
            do_op(m, q, done_at, pulses, busy_cnt, prod, stable);
            total++;
            if (int'(prod) !== want || done_at !== 4 || pulses !== 1 || busy_cnt !== 5
                || stable !== 1'b1) begin
                bad++;
                $display("[TB] FAIL random_%0dx%0d: got product=%0d cycle=%0d pulses=%0d busy=%0d stable=%b, want %0d 4 1 5 1",
                         m, q, prod, done_at, pulses, busy_cnt, stable, want);
            end
        end
    endtask

    // Scenario sequence.
    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_carry();
        test_zero();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_add_multiplier_4_bit.md
Name: shift_add_multiplier_4_bit

Overview:
- Sequential 4x4 unsigned multiplier built from the shift-and-add algorithm.
- Sits directly upstream of the 4-bit carry-lookahead adder: it drives the adder's operands each cycle and consumes its 5-bit result (carry plus sum).
- Produces an 8-bit product through a start/busy/done handshake, one partial-product step per clock.

Parameters:
- WIDTH, 4: operand width. Only 4 is legal because the adder is fixed at 4 bits. Any other value must fail elaboration.

Ports:
- i_clk  input  1  system clock; all state changes on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_start  input  1  request a multiply. Sampled only in IDLE.
- i_multiplicand  input  4  operand M, captured on the accepted start.
- i_multiplier  input  4  operand Q, captured on the accepted start.
- o_busy  output  1  high from the edge that accepts start until the edge that leaves DONE.
- o_done  output  1  one-cycle pulse; product valid.
- o_product  output  8  unsigned M*Q. Held until the next accepted start.

Behaviour:
- Clock and reset: single clock i_clk. Reset i_rst_n is asynchronous and active-low, and is the only reset.
- Reset state: state=IDLE, o_busy=0, o_done=0, o_product=8'h00. Internal regs (M, A, Q, C, count) all 0.
- Reset mid-operation aborts immediately to the reset state. No partial product appears.
- Datapath registers:
  - M[3:0] multiplicand.
  - A[3:0] upper accumulator.
  - Q[3:0] multiplier / lower product.
  - C carry bit.
  - count[1:0].
- Adder connection: inputs are A and M. The 5-bit result is {cout, sum}.
- States:
  - IDLE: on i_start=1 at edge N, load M<=i_multiplicand, Q<=i_multiplier, A<=0, C<=0, count<=0, o_busy<=1, then go to CALC. With i_start=0, stay in IDLE.
  - CALC: one step per edge at N+1..N+4.
    - If Q[0]=1, {C,A} <= adder result; otherwise {C,A} <= {0,A}.
    - Then shift right: {C,A,Q} <= {0, C', A', Q} >> 1, using the post-add values. Equivalently new A = {C',A'[3:1]}, new Q = {A'[0],Q[3:1]}, C=0.
    - count increments.
    - On the step where count==3, also register o_product <= {A_new, Q_new}, set o_done<=1, and go to DONE.
  - DONE: lasts exactly one cycle (o_done=1). At edge N+5: o_done<=0, o_busy<=0, go to IDLE.
- Latency: product valid and o_done high during the cycle after edge N+4, i.e. 4 cycles after start is accepted.
- Throughput: with i_start held high, a new operation is accepted every 6 edges (N, N+6, ...).
- i_start while busy (CALC or DONE) is ignored. Operand inputs are don't-care outside the accepting edge.
- Width rule: maximum product 15*15=225 fits in 8 bits. No overflow is possible.
- The adder carry-out must be captured every step. Dropping it is a bug; 15*15 exercises it.
- o_product is stable throughout CALC; it changes only at the final step edge.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2), the constant WIDTH=4, and the constant STEPS=4.
- Exactly one sub-module: carry_lookahead_adder_4_bit, instantiated once with inputs A and M and a 5-bit result.
- FSM, registers and shifter are local.

Test Plan:
- Reset, then i_start=1 with 6*3 -> o_done pulses 4 cycles after accept; o_product=8'h12; o_busy high for exactly 5 cycles.
- 15*15 -> o_product=8'hE1 (225). Checks carry capture on every step.
- 0*9 and 9*0 -> o_product=8'h00; o_done timing identical to the nonzero case.
- Toggle i_start and change operands during CALC with 5*7 in flight -> result 8'h23. No restart; o_done still a single pulse.
- Hold i_start high for 3 operations (1*15, 2*8, 13*11) -> results 8'h0F, 8'h10, 8'h8F. Starts accepted every 6 cycles.
- Assert i_rst_n=0 asynchronously mid-CALC -> outputs go to 0 immediately, with no o_done. After release, 4*4 -> 8'h10.
